radio_rx_framer: RTL and testbench
==================================

RADIO_RX_FRAMER -- requirements
Module: radio_rx_framer

Interface
REQ-001 The block SHALL have parameter ITEM_W, default 32, bits per sample item.
REQ-002 The block SHALL have parameter NIPC, default 1, items per radio word.
REQ-003 The block SHALL have parameter NUM_PORTS, default 1, independent channels.
REQ-004 The block SHALL have parameter FIFO_ADDR_W, default 5, per-channel FIFO depth 2**FIFO_ADDR_W entries.
REQ-005 The block SHALL have parameter SPP_W, default 14, width of spp.
REQ-006 The block SHALL have ports, in this order (W = NIPC*ITEM_W):
- radio_clk  in  1  sole clock.
- radio_rst_n  in  1  reset, asynchronous, active-low.
- radio_time  in  64  timestamp of the current radio word.
- radio_rx_stb  in  NUM_PORTS  per-channel word strobe.
- radio_rx_data  in  NUM_PORTS*W  per-channel radio word.
- run  in  NUM_PORTS  per-channel capture enable (level).
- spp  in  SPP_W  words per packet, shared by all channels.
- m_tdata  out  NUM_PORTS*W  output word.
- m_ttimestamp  out  NUM_PORTS*64  radio_time of the word.
- m_tlast  out  NUM_PORTS  last word of packet.
- m_teob  out  NUM_PORTS  end of burst, valid with m_tlast.
- m_tvalid  out  NUM_PORTS  AXI-Stream valid.
- m_tready  in  NUM_PORTS  AXI-Stream ready.
- overrun  out  NUM_PORTS  one-cycle overrun pulse.

Function
REQ-007 Each channel SHALL be an identical, independent framer; all channels share only radio_clk, radio_rst_n, radio_time and spp.
REQ-008 Each channel SHALL hold the most recent strobed word, with its radio_time, in a one-entry hold register before pushing it to the FIFO.
REQ-009 The write FSM SHALL have exactly three states: IDLE, CAPTURE and OVERRUN.
REQ-010 In IDLE, if run=1 and stb=1, the channel SHALL load the hold register, clear the word counter and enter CAPTURE; strobes with run=0 SHALL be ignored.
REQ-011 In CAPTURE, if stb=1 and run=1, the channel SHALL push the held word and load the new word in the same cycle.
REQ-012 The pushed word SHALL carry tlast=1 when word count = spp-1, after which the counter wraps to 0.
REQ-013 If run=0 in CAPTURE, the channel SHALL push the held word with tlast=1 and teob=1, return to IDLE, and ignore any stb in that cycle.
REQ-014 spp=0 SHALL be treated as 1.
REQ-015 spp SHALL be sampled when each packet's first word is held and stay constant for that packet.
REQ-016 Fullness SHALL be judged on occupancy at cycle start; a pop in the same cycle SHALL NOT be credited.
REQ-017 If a push is required and free entries = 1, the held word SHALL be pushed with tlast=1 and teob=1, overrun SHALL pulse for one cycle, and the FSM SHALL enter OVERRUN.
REQ-018 In OVERRUN, all strobes SHALL be discarded until run=0, after which the FSM SHALL enter IDLE.
REQ-019 A packet SHALL never be emitted without tlast, and the FIFO SHALL never be written when full.
REQ-020 The FIFO SHALL be first-word-fall-through: an entry written at edge N SHALL drive m_tvalid=1 after edge N+1.
REQ-021 A pop SHALL occur only on m_tvalid and m_tready both high, and m_tvalid SHALL drop only when the FIFO is empty.
REQ-022 While m_tvalid=1 and m_tready=0, all m_* outputs SHALL be held stable.
REQ-023 Pointers SHALL be FIFO_ADDR_W+1 bits, wrapping modulo 2**(FIFO_ADDR_W+1); full and empty SHALL be decoded from the MSB comparison.

Reset
REQ-024 While radio_rst_n=0, all outputs SHALL be 0, FIFOs empty, hold registers invalid, counters 0 and the FSM in IDLE.
REQ-025 Reset asserted mid-packet SHALL discard all partial data with no tlast emitted; the first post-reset packet SHALL start clean.
REQ-026 Reset deassertion SHALL be synchronised to radio_clk internally.

Verification
REQ-027 spp=4, run=1, 8 strobes with radio_time=100..107, then run=0, tready=1 -> packets [100..103] and [104..107]; tlast on words 4 and 8; teob=1 on word 8 only.
REQ-028 spp=4, run falls after 6 strobes -> packets of 4 and 2 words; second packet tlast=1 and teob=1; overrun never asserted.
REQ-029 FIFO_ADDR_W=3, tready=0, continuous strobes -> exactly 8 entries, entry 8 has tlast=1 and teob=1, one overrun pulse; run low then high -> new burst starts with counter 0.
REQ-030 spp=0, 3 strobes then run=0 -> 3 single-word packets, each tlast=1, teob only on the third.
REQ-031 Reset pulsed after 2 words of spp=4 -> outputs 0 during reset; afterwards m_tvalid=0 until a new run; no orphan words.
REQ-032 NUM_PORTS=3, STB_PROB 80%, tready stall 25%, random run toggling -> each channel matches an independent scoreboard, with no overrun pulse unless its FIFO filled.

Source files
------------

// File: rtl/radio_rx_framer.sv
// Radio RX framer: per-channel capture of strobed radio words into timestamped
// AXI-Stream packets of spp words, with burst end (teob) and overrun handling.
module radio_rx_framer #(
    parameter int ITEM_W      = 32,
    parameter int NIPC        = 1,
    parameter int NUM_PORTS   = 1,
    parameter int FIFO_ADDR_W = 5,
    parameter int SPP_W       = 14
) (
    input  logic                             radio_clk,
    input  logic                             radio_rst_n,
    input  logic [63:0]                      radio_time,
    input  logic [NUM_PORTS-1:0]             radio_rx_stb,
    input  logic [NUM_PORTS*NIPC*ITEM_W-1:0] radio_rx_data,
    input  logic [NUM_PORTS-1:0]             run,
    input  logic [SPP_W-1:0]                 spp,
    output logic [NUM_PORTS*NIPC*ITEM_W-1:0] m_tdata,
    output logic [NUM_PORTS*64-1:0]          m_ttimestamp,
    output logic [NUM_PORTS-1:0]             m_tlast,
    output logic [NUM_PORTS-1:0]             m_teob,
    output logic [NUM_PORTS-1:0]             m_tvalid,
    input  logic [NUM_PORTS-1:0]             m_tready,
    output logic [NUM_PORTS-1:0]             overrun
);
    localparam int W     = NIPC * ITEM_W;
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int ENT_W = W + 64 + 2;

    localparam logic [SPP_W-1:0]       SPP_ONE  = SPP_W'(1);
    localparam logic [FIFO_ADDR_W:0]   PTR_ONE  = (FIFO_ADDR_W + 1)'(1);
    localparam logic [FIFO_ADDR_W:0]   ALMOST   = (FIFO_ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, OVERRUN} state_t;

    function automatic logic [SPP_W-1:0] eff_spp(input logic [SPP_W-1:0] s);
        return (s == '0) ? SPP_ONE : s;
    endfunction

    // Asynchronous assertion, deassertion released through two radio_clk flops.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    for (genvar c = 0; c < NUM_PORTS; c++) begin : g_chan
        state_t               state;
        logic [W-1:0]         hold_data;
        logic [63:0]          hold_time;
        logic                 hold_vld;
        logic [SPP_W-1:0]     cnt;
        logic [SPP_W-1:0]     pkt_spp;
        logic [FIFO_ADDR_W:0] wr_ptr;
        logic [FIFO_ADDR_W:0] rd_ptr;
        logic [FIFO_ADDR_W:0] used;
        logic [ENT_W-1:0]     mem [DEPTH];
        logic [ENT_W-1:0]     rd_ent;
        logic                 vld;
        logic                 ovr;
        logic                 stb;
        logic                 go;
        logic                 pop;
        logic                 last_word;
        logic                 fifo_empty;
        logic                 fifo_full;
        logic                 one_free;
        logic                 push;
        logic                 push_last;
        logic                 push_eob;
        logic                 load;
        logic                 drop;
        logic                 wr_en;
        logic [W-1:0]         din;

        assign stb        = radio_rx_stb[c];
        assign go         = run[c];
        assign din        = radio_rx_data[c*W +: W];
        assign used       = wr_ptr - rd_ptr;
        assign fifo_empty = (wr_ptr == rd_ptr);
        assign fifo_full  = (wr_ptr[FIFO_ADDR_W] != rd_ptr[FIFO_ADDR_W]) &&
                            (wr_ptr[FIFO_ADDR_W-1:0] == rd_ptr[FIFO_ADDR_W-1:0]);
        assign one_free   = (used == ALMOST);
        assign pop        = vld & m_tready[c];
        assign last_word  = (cnt == pkt_spp - SPP_ONE);
        assign wr_en      = push & ~fifo_full;

        // Occupancy is judged at cycle start; a same-cycle pop earns no credit.
        always_comb begin
            push      = 1'b0;
            push_last = 1'b0;
            push_eob  = 1'b0;
            load      = 1'b0;
            drop      = 1'b0;
            case (state)
                IDLE: begin
                    load = go & stb;
                end
                CAPTURE: begin
                    if (!go) begin
                        push      = hold_vld;
                        push_last = 1'b1;
                        push_eob  = 1'b1;
                    end else if (stb) begin
                        push      = hold_vld;
                        push_last = last_word;
                        load      = 1'b1;
                    end
                    if (push && (one_free || fifo_full)) begin
                        push_last = 1'b1;
                        push_eob  = 1'b1;
                        load      = 1'b0;
                        drop      = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        always_ff @(posedge radio_clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE;
                cnt      <= '0;
                pkt_spp  <= SPP_ONE;
                hold_vld <= 1'b0;
                ovr      <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                vld      <= 1'b0;
            end else begin
                ovr <= drop;
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                // A word written this edge only becomes visible one edge later.
                vld <= ~fifo_empty & ~(pop & (used == PTR_ONE));
                case (state)
                    IDLE: begin
                        if (load) begin
                            state    <= CAPTURE;
                            cnt      <= '0;
                            pkt_spp  <= eff_spp(spp);
                            hold_vld <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (drop) begin
                            state    <= OVERRUN;
                            hold_vld <= 1'b0;
                        end else if (!go) begin
                            state    <= IDLE;
                            hold_vld <= 1'b0;
                        end else if (load) begin
                            if (last_word) begin
                                cnt     <= '0;
                                pkt_spp <= eff_spp(spp);
                            end else begin
                                cnt <= cnt + SPP_ONE;
                            end
                        end
                    end
                    OVERRUN: begin
                        if (!go) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge radio_clk) begin
            if (load) begin
                hold_data <= din;
                hold_time <= radio_time;
            end
        end

        always_ff @(posedge radio_clk) begin
            if (wr_en) begin
                mem[wr_ptr[FIFO_ADDR_W-1:0]] <= {push_last, push_eob, hold_time, hold_data};
            end
        end

        assign rd_ent = mem[rd_ptr[FIFO_ADDR_W-1:0]];

        assign m_tdata[c*W +: W]        = vld ? rd_ent[W-1:0] : '0;
        assign m_ttimestamp[c*64 +: 64] = vld ? rd_ent[W+63:W] : '0;
        assign m_teob[c]                = vld & rd_ent[W+64];
        assign m_tlast[c]               = vld & rd_ent[W+65];
        assign m_tvalid[c]              = vld;
        assign overrun[c]               = ovr;
    end

endmodule

// File: tb/tb_radio_rx_framer.sv
// Bench for radio_rx_framer: per-channel packet model checked every cycle,
// plus literal packet-shape expectations for the directed scenarios.
module tb_radio_rx_framer;
    localparam int NP  = 3;
    localparam int DEP = 8;

    logic          clk;
    logic          radio_rst_n;
    logic [63:0]   radio_time;
    logic [NP-1:0] radio_rx_stb;
    logic [NP*32-1:0] radio_rx_data;
    logic [NP-1:0] run;
    logic [13:0]   spp;
    logic [NP*32-1:0] m_tdata;
    logic [NP*64-1:0] m_ttimestamp;
    logic [NP-1:0] m_tlast;
    logic [NP-1:0] m_teob;
    logic [NP-1:0] m_tvalid;
    logic [NP-1:0] m_tready;
    logic [NP-1:0] overrun;

    radio_rx_framer #(
        .ITEM_W(32), .NIPC(1), .NUM_PORTS(NP), .FIFO_ADDR_W(3), .SPP_W(14)
    ) dut (
        .radio_clk(clk),
        .radio_rst_n(radio_rst_n),
        .radio_time(radio_time),
        .radio_rx_stb(radio_rx_stb),
        .radio_rx_data(radio_rx_data),
        .run(run),
        .spp(spp),
        .m_tdata(m_tdata),
        .m_ttimestamp(m_ttimestamp),
        .m_tlast(m_tlast),
        .m_teob(m_teob),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 = not capturing, 1 = capturing, 2 = discarding until run drops.
    int          ph   [NP];
    logic [31:0] hd   [NP];
    logic [63:0] ht   [NP];
    int          pos  [NP];
    int          plen [NP];
    logic [31:0] fd   [NP][DEP];
    logic [63:0] ft   [NP][DEP];
    bit          fl   [NP][DEP];
    bit          fe   [NP][DEP];
    int          head [NP];
    int          cnt  [NP];
    bit          ev   [NP];
    bit          eo   [NP];
    int          age;

    // Channel-0 log of what the DUT actually handed over.
    logic [63:0] lg_t [64];
    bit          lg_l [64];
    bit          lg_e [64];
    int          lg_n;
    int          ovc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NP; c++) begin
            ph[c] = 0; pos[c] = 0; plen[c] = 1; head[c] = 0; cnt[c] = 0;
            ev[c] = 1'b0; eo[c] = 1'b0;
        end
    endtask

    task automatic model_chan(input int c);
        bit rn, sb, pop, wr, wl, we, ld, ov;
        int cnt0, nplen, t;
        rn = run[c]; sb = radio_rx_stb[c];
        cnt0 = cnt[c];
        pop = ev[c] && m_tready[c];
        wr = 0; wl = 0; we = 0; ld = 0; ov = 0;
        nplen = (spp == 14'd0) ? 1 : int'(spp);
        if (ph[c] == 0) begin
            ld = rn && sb;
        end else if (ph[c] == 1) begin
            if (!rn) begin
                wr = 1; wl = 1; we = 1;
            end else if (sb) begin
                wr = 1; wl = (pos[c] == plen[c] - 1); ld = 1;
            end
            if (wr && (DEP - cnt0) <= 1) begin
                ov = 1; ld = 0; wl = 1; we = 1;
                if (DEP - cnt0 == 0) wr = 0;
            end
        end
        ev[c] = (cnt0 - (pop ? 1 : 0)) > 0;
        eo[c] = ov;
        if (pop) begin
            head[c] = (head[c] + 1) % DEP;
            cnt[c]--;
        end
        if (wr) begin
            t = (head[c] + cnt[c]) % DEP;
            fd[c][t] = hd[c]; ft[c][t] = ht[c]; fl[c][t] = wl; fe[c][t] = we;
            cnt[c]++;
        end
        if (ph[c] == 0) begin
            if (ld) begin ph[c] = 1; pos[c] = 0; plen[c] = nplen; end
        end else if (ph[c] == 1) begin
            if (ov) ph[c] = 2;
            else if (!rn) ph[c] = 0;
            else if (ld) begin
                if (wl) begin pos[c] = 0; plen[c] = nplen; end
                else pos[c]++;
            end
        end else begin
            if (!rn) ph[c] = 0;
        end
        if (ld) begin
            hd[c] = radio_rx_data[c*32 +: 32];
            ht[c] = radio_time;
        end
    endtask

    task automatic model_edge();
        if (!radio_rst_n) begin
            model_clear();
            age = 0;
        end else if (age < 2) begin
            age++;
        end else begin
            for (int c = 0; c < NP; c++) model_chan(c);
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < NP; c++) begin
            int h;
            h = head[c];
            chk($sformatf("tvalid%0d", c), 64'(m_tvalid[c]), 64'(ev[c]));
            chk($sformatf("overrun%0d", c), 64'(overrun[c]), 64'(eo[c]));
            if (ev[c]) begin
                chk($sformatf("tdata%0d", c), 64'(m_tdata[c*32 +: 32]), 64'(fd[c][h]));
                chk($sformatf("tstamp%0d", c), m_ttimestamp[c*64 +: 64], ft[c][h]);
                chk($sformatf("tlast%0d", c), 64'(m_tlast[c]), 64'(fl[c][h]));
                chk($sformatf("teob%0d", c), 64'(m_teob[c]), 64'(fe[c][h]));
            end
            if (!radio_rst_n) begin
                chk($sformatf("rst_tdata%0d", c), 64'(m_tdata[c*32 +: 32]), 64'd0);
                chk($sformatf("rst_tstamp%0d", c), m_ttimestamp[c*64 +: 64], 64'd0);
                chk($sformatf("rst_flags%0d", c), 64'({m_tlast[c], m_teob[c]}), 64'd0);
            end
        end
        if (overrun[0]) ovc++;
    endtask

    task automatic step();
        for (int c = 0; c < NP; c++)
            radio_rx_data[c*32 +: 32] = {8'hC0 + 8'(c), radio_time[23:0]};
        if (m_tvalid[0] && m_tready[0] && lg_n < 64) begin
            lg_t[lg_n] = m_ttimestamp[63:0];
            lg_l[lg_n] = m_tlast[0];
            lg_e[lg_n] = m_teob[0];
            lg_n++;
        end
        model_edge();
        @(posedge clk);
        #1;
        radio_time = radio_time + 64'd1;
        check_outputs();
    endtask

    task automatic clr_log();
        lg_n = 0;
        ovc  = 0;
    endtask

    task automatic check_log(input string tag, input int n, input logic [63:0] t0,
                             input int lmask, input int emask, input int novr);
        chk({tag, "_count"}, 64'(lg_n), 64'(n));
        chk({tag, "_first_time"}, lg_t[0], t0);
        for (int i = 0; i < n && i < lg_n; i++) begin
            chk($sformatf("%s_last%0d", tag, i), 64'(lg_l[i]), 64'((lmask >> i) & 1));
            chk($sformatf("%s_eob%0d", tag, i), 64'(lg_e[i]), 64'((emask >> i) & 1));
        end
        chk({tag, "_overruns"}, 64'(ovc), 64'(novr));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        radio_rst_n = 1'b0; run = '0; radio_rx_stb = '0; m_tready = '1;
        spp = 14'd4; radio_time = 64'd0; radio_rx_data = '0;
        model_clear(); age = 0; clr_log();
        repeat (3) step();
        radio_rst_n = 1'b1;
        repeat (5) step();

        // Two full packets, burst ends on the eighth word.
        clr_log(); spp = 14'd4; radio_time = 64'd100; run[0] = 1; radio_rx_stb[0] = 1;
        repeat (8) step();
        run[0] = 0; radio_rx_stb[0] = 0;
        repeat (12) step();
        check_log("A", 8, 64'd100, 'h88, 'h80, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("A_time%0d", i), lg_t[i], 64'(100 + i));

        // Run falls after six words; strobes while stopped are ignored.
        clr_log(); spp = 14'd4; radio_time = 64'd150; run[0] = 1; radio_rx_stb[0] = 1;
        repeat (6) step();
        run[0] = 0;
        repeat (10) step();
        radio_rx_stb[0] = 0;
        check_log("B", 6, 64'd150, 'h28, 'h20, 0);

        // Stalled consumer: eight entries, last forced, one overrun, fresh burst after.
        clr_log(); spp = 14'd5; radio_time = 64'd200; m_tready[0] = 0;
        run[0] = 1; radio_rx_stb[0] = 1;
        repeat (14) step();
        run[0] = 0; radio_rx_stb[0] = 0;
        step();
        m_tready[0] = 1;
        repeat (12) step();
        run[0] = 1; radio_rx_stb[0] = 1;
        repeat (4) step();
        run[0] = 0; radio_rx_stb[0] = 0;
        repeat (10) step();
        check_log("C", 12, 64'd200, 'h890, 'h880, 1);
        chk("C_time7", lg_t[7], 64'd207);

        // spp of zero behaves as one word per packet.
        clr_log(); spp = 14'd0; radio_time = 64'd300; run[0] = 1; radio_rx_stb[0] = 1;
        repeat (3) step();
        run[0] = 0; radio_rx_stb[0] = 0;
        repeat (8) step();
        check_log("D", 3, 64'd300, 'h7, 'h4, 0);

        // Reset mid-packet with words already queued.
        clr_log(); spp = 14'd4; radio_time = 64'd400; m_tready[0] = 0;
        run[0] = 1; radio_rx_stb[0] = 1;
        repeat (3) step();
        chk("E_valid_before_reset", 64'(m_tvalid[0]), 64'd1);
        radio_rst_n = 1'b0;
        model_clear(); age = 0;
        #1;
        chk("E_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("E_rst_tdata", m_tdata[63:0], 64'd0);
        chk("E_rst_tstamp", m_ttimestamp[63:0], 64'd0);
        chk("E_rst_overrun", 64'(overrun), 64'd0);
        run[0] = 0; radio_rx_stb[0] = 0;
        repeat (3) step();
        radio_rst_n = 1'b1; m_tready[0] = 1;
        repeat (8) step();
        chk("E_no_orphans", 64'(lg_n), 64'd0);
        radio_time = 64'd500; run[0] = 1; radio_rx_stb[0] = 1;
        repeat (4) step();
        run[0] = 0; radio_rx_stb[0] = 0;
        repeat (10) step();
        check_log("E", 4, 64'd500, 'h8, 'h8, 0);

        // All channels, random strobes, stalls, run toggling and spp changes.
        for (int k = 0; k < 1500; k++) begin
            if (k % 64 == 0) spp = 14'($urandom_range(6));
            for (int c = 0; c < NP; c++) begin
                if ($urandom_range(99) < 4) run[c] = ~run[c];
                radio_rx_stb[c] = ($urandom_range(99) < 80);
                m_tready[c] = ($urandom_range(99) >= 25);
            end
            step();
        end
        run = '0; radio_rx_stb = '0; m_tready = '1;
        repeat (30) step();
        chk("F_drained", 64'(m_tvalid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
